// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 16x oversampled 8N1 UART receiver with valid/ready holding register
module uart_receiver (
  input  logic       uart_sampling_clk,
  input  logic       reset,
  input  logic       RsRx,
  output logic       valid,
  input  logic       ready,
  output logic [7:0] data_received,
  output logic       framing_error,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        rx_s_q, rx_s_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        bad_q, bad_d;
  logic        valid_q, valid_d;
  logic [7:0]  data_q, data_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic        byte_done;

  assign valid         = valid_q;
  assign data_received = data_q;
  assign framing_error = ferr_q;
  assign overrun       = ovr_q;

  // State register: synchronizer, frame FSM, holding register and event pulses
  always_ff @(posedge uart_sampling_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_q     <= 4'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      bad_q     <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= 8'h00;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      rx_s_q    <= rx_s_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      bad_q     <= bad_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  // Next-state: mid-bit sampling of the synchronized line and handshake with the consumer
  always_comb begin
    state_d   = state_q;
    sync1_d   = RsRx;
    rx_s_d    = sync1_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    bad_d     = bad_q;
    valid_d   = valid_q;
    data_d    = data_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    byte_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = 4'd0;
        end
      end
      START: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd7) begin
          // Line must still be low at the middle of the start bit, else it was a glitch
          if (!rx_s_q) begin
            state_d   = DATA;
            cnt_d     = 4'd0;
            bit_idx_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          cnt_d     = 4'd0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          if (rx_s_q) begin
            state_d   = IDLE;
            cnt_d     = 4'd0;
            bad_d     = 1'b0;
            byte_done = !bad_q;
          end else begin
            // Hold here until the line recovers; bad_q keeps the error to a single pulse
            cnt_d  = 4'd15;
            ferr_d = !bad_q;
            bad_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (byte_done) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed and randomized frame-level checks for uart_receiver
module tb_uart_receiver;

  logic       clk;
  logic       reset;
  logic       RsRx;
  logic       valid;
  logic       ready;
  logic [7:0] data_received;
  logic       framing_error;
  logic       overrun;

  int checks;
  int failures;

  uart_receiver dut (
    .uart_sampling_clk(clk),
    .reset(reset),
    .RsRx(RsRx),
    .valid(valid),
    .ready(ready),
    .data_received(data_received),
    .framing_error(framing_error),
    .overrun(overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter: after posedge k, cyc == k
  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records accepted bytes, pulses and hold violations at the falling edge
  int       n_valid_hi;
  int       n_acc;
  int       n_ferr;
  int       n_ovr;
  int       n_hold_viol;
  int       last_rise;
  int       ferr_run;
  int       ovr_run;
  int       max_ferr_run;
  int       max_ovr_run;
  bit       prev_valid;
  bit       prev_ready;
  logic [7:0] prev_data;
  logic [7:0] acc_mem [256];

  always @(negedge clk) begin
    if (valid === 1'b1) n_valid_hi <= n_valid_hi + 1;
    if (valid === 1'b1 && !prev_valid) last_rise <= cyc;
    if (valid === 1'b1 && ready === 1'b1) begin
      acc_mem[n_acc[7:0]] <= data_received;
      n_acc <= n_acc + 1;
    end
    if (prev_valid && !prev_ready && !(valid === 1'b1 && data_received === prev_data))
      n_hold_viol <= n_hold_viol + 1;
    if (framing_error === 1'b1) begin
      n_ferr   <= n_ferr + 1;
      ferr_run <= ferr_run + 1;
      if (ferr_run + 1 > max_ferr_run) max_ferr_run <= ferr_run + 1;
    end else begin
      ferr_run <= 0;
    end
    if (overrun === 1'b1) begin
      n_ovr   <= n_ovr + 1;
      ovr_run <= ovr_run + 1;
      if (ovr_run + 1 > max_ovr_run) max_ovr_run <= ovr_run + 1;
    end else begin
      ovr_run <= 0;
    end
    prev_valid <= (valid === 1'b1);
    prev_ready <= (ready === 1'b1);
    prev_data  <= data_received;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives start, 8 data bits LSB first and one stop bit; line is left at stop_val
  task automatic send_frame(input logic [7:0] b, input logic stop_val, output int e0);
    e0 = cyc + 1;
    RsRx = 1'b0;
    idle(16);
    for (int i = 0; i < 8; i++) begin
      RsRx = b[i];
      idle(16);
    end
    RsRx = stop_val;
    idle(16);
  endtask

  logic [7:0] exp_q[$];
  int e0;
  int bv, ba, bf, bo;
  logic [7:0] rb;

  initial begin
    checks   = 0;
    failures = 0;
    RsRx  = 1'b1;
    ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_data", {24'd0, data_received}, 32'd0);
    check("rst_ferr", {31'd0, framing_error}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    reset = 1'b0;
    idle(20);

    // A5 with ready high: valid rises right after E154 for one cycle
    bv = n_valid_hi; ba = n_acc; bf = n_ferr; bo = n_ovr;
    send_frame(8'hA5, 1'b1, e0);
    idle(20);
    check("a5_rise_cycle", last_rise, e0 + 154);
    check("a5_valid_cycles", n_valid_hi - bv, 1);
    check("a5_accept_count", n_acc - ba, 1);
    check("a5_data", {24'd0, acc_mem[ba[7:0]]}, 32'hA5);
    check("a5_no_ferr", n_ferr - bf, 0);
    check("a5_no_ovr", n_ovr - bo, 0);

    // 3C held while ready low for 500 cycles
    ready = 1'b0;
    ba = n_acc;
    send_frame(8'h3C, 1'b1, e0);
    idle(340);
    check("3c_held_valid", {31'd0, valid}, 32'd1);
    check("3c_held_data", {24'd0, data_received}, 32'h3C);
    check("3c_hold_viol", n_hold_viol, 0);
    ready = 1'b1;
    @(negedge clk);
    check("3c_valid_before_accept", {31'd0, valid}, 32'd1);
    idle(1);
    check("3c_valid_cleared", {31'd0, valid}, 32'd0);
    check("3c_accept", {24'd0, acc_mem[ba[7:0]]}, 32'h3C);

    // 55 arrives while 12 still pending: overrun, 12 kept
    ready = 1'b0;
    ba = n_acc; bo = n_ovr;
    send_frame(8'h12, 1'b1, e0);
    idle(20);
    send_frame(8'h55, 1'b1, e0);
    idle(20);
    check("ovr_pulses", n_ovr - bo, 1);
    check("ovr_data_kept", {24'd0, data_received}, 32'h12);
    check("ovr_valid_kept", {31'd0, valid}, 32'd1);
    ready = 1'b1;
    idle(4);
    check("ovr_accept_count", n_acc - ba, 1);
    check("ovr_accept_data", {24'd0, acc_mem[ba[7:0]]}, 32'h12);
    check("ovr_valid_cleared", {31'd0, valid}, 32'd0);

    // Stop bit low for two bit times: one framing error, no byte; then 81
    bv = n_valid_hi; bf = n_ferr; ba = n_acc;
    send_frame(8'h00, 1'b0, e0);
    idle(16);
    RsRx = 1'b1;
    idle(32);
    check("ferr_pulses", n_ferr - bf, 1);
    check("ferr_no_valid", n_valid_hi - bv, 0);
    send_frame(8'h81, 1'b1, e0);
    idle(20);
    check("after_ferr_count", n_acc - ba, 1);
    check("after_ferr_data", {24'd0, acc_mem[ba[7:0]]}, 32'h81);
    check("after_ferr_no_new_ferr", n_ferr - bf, 1);

    // Start glitch shorter than half a bit is rejected
    bv = n_valid_hi; bf = n_ferr;
    RsRx = 1'b0;
    idle(4);
    RsRx = 1'b1;
    idle(200);
    check("glitch_no_valid", n_valid_hi - bv, 0);
    check("glitch_no_ferr", n_ferr - bf, 0);

    // Reset in the middle of an FF frame, then a 00 frame
    bv = n_valid_hi; bf = n_ferr; bo = n_ovr; ba = n_acc;
    RsRx = 1'b0;
    idle(16);
    RsRx = 1'b1;
    idle(50);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(200);
    check("midrst_no_valid", n_valid_hi - bv, 0);
    check("midrst_no_ferr", n_ferr - bf, 0);
    check("midrst_no_ovr", n_ovr - bo, 0);
    send_frame(8'h00, 1'b1, e0);
    idle(20);
    check("midrst_next_count", n_acc - ba, 1);
    check("midrst_next_data", {24'd0, acc_mem[ba[7:0]]}, 32'h00);

    // Random bytes, mostly back-to-back, consumer always ready
    ready = 1'b1;
    ba = n_acc; bf = n_ferr; bo = n_ovr;
    for (int i = 0; i < 10; i++) begin
      rb = 8'($urandom_range(0, 255));
      exp_q.push_back(rb);
      send_frame(rb, 1'b1, e0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 20));
    end
    idle(30);
    check("rand_count", n_acc - ba, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("rand_byte_%0d", i), {24'd0, acc_mem[8'(ba + i)]}, {24'd0, exp_q[i]});
    end
    check("rand_no_ferr", n_ferr - bf, 0);
    check("rand_no_ovr", n_ovr - bo, 0);

    check("ferr_max_run", max_ferr_run, 1);
    check("ovr_max_run", max_ovr_run, 1);
    check("hold_viol_total", n_hold_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
